// File: rtl/vedic_utm_seq_mult_if.sv
// Operand/product handshake bundle for the column-serial Vedic multiplier.
// Valid/ready: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds valid (and its payload) stable until then.
// The state field carries the multiplier's FSM state for observation.
interface vedic_utm_seq_mult_if #(
  parameter int N = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [2*N-1:0] product;
  logic         busy;
  logic [1:0]   state;

  // Upstream/downstream side: supplies operands, consumes the product.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy, state
  );

  // Multiplier side.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy, state
  );
endinterface

// File: rtl/vedic_utm_seq_mult.sv
// Column-serial Urdhva-Tiryakbhyam unsigned multiplier.
// One crosswise column (all bit pairs with i+j=k) plus the running carry is
// resolved per clock; 2N-1 columns produce the full 2N-bit product, the last
// carry bit landing in the product MSB.
module vedic_utm_seq_mult #(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  vedic_utm_seq_mult_if.slave   bus
);

  // Column sum width: enough for N partial products plus the incoming carry.
  localparam int CW = $clog2(2*N) + 1;
  localparam int KW = $clog2(2*N);
  localparam logic [KW-1:0] K_LAST = KW'(2*N - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [N-1:0]    a_r;
  logic [N-1:0]    b_r;
  logic [KW-1:0]   k;
  logic [CW-2:0]   carry;
  logic [CW-1:0]   col_sum;
  logic [2*N-1:0]  product;
  logic            in_ready;
  logic            out_valid;
  logic            busy;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.product   = product;
  assign bus.busy      = busy;
  assign bus.state     = state;

  // Crosswise column k: carry plus every a_r[i]&b_r[j] with i+j == k.
  always_comb begin
    col_sum = {1'b0, carry};
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (i + j == int'(k)) begin
          col_sum = col_sum + CW'(a_r[i] & b_r[j]);
        end
      end
    end
  end

  // Control FSM with registered handshake outputs and the product shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      k         <= '0;
      carry     <= '0;
      a_r       <= '0;
      b_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready) begin
            a_r      <= bus.a;
            b_r      <= bus.b;
            carry    <= '0;
            product  <= '0;
            k        <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          product[k] <= col_sum[0];
          carry      <= col_sum[CW-1:1];
          k          <= k + 1'b1;
          if (k == K_LAST) begin
            // Final carry is at most one bit and becomes the product MSB.
            product[2*N-1] <= col_sum[1];
            out_valid      <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_utm_seq_mult.sv
// Bench for the column-serial Vedic multiplier: an N=4 instance for directed,
// exhaustive and randomized checks, and an N=8 instance for wide operands.
// Expected products come from plain integer multiplication.
module tb_vedic_utm_seq_mult;

  localparam int N  = 4;
  localparam int N8 = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  vedic_utm_seq_mult_if #(.N(N))  bus4 ();
  vedic_utm_seq_mult_if #(.N(N8)) bus8 ();

  vedic_utm_seq_mult #(.N(N))  dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  vedic_utm_seq_mult #(.N(N8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] exp;
    int             hold;
  } vec_t;

  vec_t vecs[6];

  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the N=4 instance; hold = cycles of backpressure in DONE.
  task automatic run_op4(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input int hold,
                         input string name);
    int lat;
    logic [63:0] exp;
    exp = 64'(ta) * 64'(tb_v);
    exp_q.push_back(exp);
    bus4.out_ready = (hold == 0);
    check({name, " in_ready before issue"}, 64'(bus4.in_ready), 64'd1);
    bus4.in_valid = 1'b1;
    bus4.a = ta;
    bus4.b = tb_v;
    tick();
    bus4.in_valid = 1'b0;
    bus4.a = N'($urandom);
    bus4.b = N'($urandom);
    check({name, " busy after accept"}, 64'(bus4.busy), 64'd1);
    lat = 0;
    while (!bus4.out_valid && lat < 4*N + 4) begin
      tick();
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(2*N - 1));
    exp = exp_q.pop_front();
    check({name, " product"}, 64'(bus4.product), exp);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({name, " held valid"}, 64'(bus4.out_valid), 64'd1);
      check({name, " held product"}, 64'(bus4.product), exp);
    end
    bus4.out_ready = 1'b1;
    tick();
    check({name, " valid drop"}, 64'(bus4.out_valid), 64'd0);
    check({name, " back to idle"}, 64'(bus4.in_ready), 64'd1);
  endtask

  // One transaction on the N=8 instance, downstream always ready.
  task automatic run_op8(input logic [N8-1:0] ta, input logic [N8-1:0] tb_v, input string name);
    int lat;
    logic [63:0] exp;
    exp = 64'(ta) * 64'(tb_v);
    bus8.out_ready = 1'b1;
    bus8.in_valid  = 1'b1;
    bus8.a = ta;
    bus8.b = tb_v;
    tick();
    bus8.in_valid = 1'b0;
    bus8.a = N8'($urandom);
    bus8.b = N8'($urandom);
    lat = 0;
    while (!bus8.out_valid && lat < 4*N8 + 4) begin
      tick();
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(2*N8 - 1));
    check({name, " product"}, 64'(bus8.product), exp);
    tick();
    check({name, " back to idle"}, 64'(bus8.in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b1;

    vecs[0] = '{a: 4'd15, b: 4'd15, exp: 8'hE1, hold: 0};
    vecs[1] = '{a: 4'd0,  b: 4'd9,  exp: 8'h00, hold: 0};
    vecs[2] = '{a: 4'd1,  b: 4'd13, exp: 8'h0D, hold: 0};
    vecs[3] = '{a: 4'd12, b: 4'd11, exp: 8'h84, hold: 2};
    vecs[4] = '{a: 4'd3,  b: 4'd5,  exp: 8'h0F, hold: 0};
    vecs[5] = '{a: 4'd9,  b: 4'd0,  exp: 8'h00, hold: 1};

    // Reset for two cycles.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset in_ready", 64'(bus4.in_ready), 64'd1);
    check("reset out_valid", 64'(bus4.out_valid), 64'd0);
    check("reset busy", 64'(bus4.busy), 64'd0);
    check("reset product", 64'(bus4.product), 64'd0);
    check("reset n8 product", 64'(bus8.product), 64'd0);

    // Directed table: product checked against the table constant as well.
    for (int v = 0; v < 6; v++) begin
      run_op4(vecs[v].a, vecs[v].b, vecs[v].hold, $sformatf("vec%0d", v));
      check($sformatf("vec%0d table product", v), 64'(bus4.product), 64'(vecs[v].exp));
    end

    // Backpressure with a competing in_valid that must be ignored.
    bus4.out_ready = 1'b0;
    bus4.in_valid = 1'b1; bus4.a = 4'd12; bus4.b = 4'd11;
    tick();
    bus4.in_valid = 1'b0;
    lat = 0;
    while (!bus4.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("bp latency", 64'(lat), 64'd7);
    for (int h = 0; h < 5; h++) begin
      bus4.in_valid = 1'b1; bus4.a = 4'd1; bus4.b = 4'd1;
      tick();
      check("bp valid held", 64'(bus4.out_valid), 64'd1);
      check("bp product held", 64'(bus4.product), 64'h84);
      check("bp in_ready low", 64'(bus4.in_ready), 64'd0);
    end
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1;
    tick();
    check("bp release valid", 64'(bus4.out_valid), 64'd0);
    check("bp product kept", 64'(bus4.product), 64'h84);
    // out_ready high with nothing pending has no effect.
    tick();
    check("idle out_ready no effect", 64'(bus4.out_valid), 64'd0);

    // Reset in the middle of CALC (after k reaches 3).
    bus4.in_valid = 1'b1; bus4.a = 4'd7; bus4.b = 4'd9;
    tick();
    bus4.in_valid = 1'b0;
    tick(); tick(); tick();
    check("mid busy before rst", 64'(bus4.busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid rst in_ready", 64'(bus4.in_ready), 64'd1);
    check("mid rst busy", 64'(bus4.busy), 64'd0);
    check("mid rst product", 64'(bus4.product), 64'd0);
    lat = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus4.out_valid) lat++;
    end
    check("mid rst no output", 64'(lat), 64'd0);
    run_op4(4'd3, 4'd5, 0, "after rst");
    check("after rst value", 64'(bus4.product), 64'h0F);

    // Exhaustive sweep.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        run_op4(4'(ai), 4'(bi), 0, $sformatf("sweep %0d*%0d", ai, bi));
      end
    end

    // Random operands with random backpressure.
    for (int r = 0; r < 100; r++) begin
      run_op4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)), $sformatf("rand4 #%0d", r));
    end

    // Wide instance: corner and random.
    run_op8(8'd255, 8'd255, "n8 max");
    check("n8 max value", 64'(bus8.product), 64'hFE01);
    run_op8(8'd0, 8'd255, "n8 zero");
    for (int r = 0; r < 1000; r++) begin
      run_op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $sformatf("rand8 #%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
